// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - two-phase instruction fetch/issue sequencer with call/return stack
module fetch_sequencer #(
    parameter logic [10:0] RESET_VECTOR = 11'h000,
    parameter int          STACK_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] Rom_addr_out,
    input  logic [13:0] Rom_data_in,
    output logic [13:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        goto_en,
    input  logic        call_en,
    input  logic        ret_en,
    input  logic        skip_en,
    input  logic [10:0] target_in,
    output logic [10:0] pc_out,
    output logic        stack_ovf,
    output logic        stack_unf
);

    // SP counts 0..STACK_DEPTH inclusive, so it needs one more code than the depth.
    localparam int SPW   = $clog2(STACK_DEPTH + 1);
    localparam int SLOTS = 1 << SPW;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [10:0]    pc_q, pc_d;
    logic [13:0]    ir_q, ir_d;
    logic [10:0]    pcout_q, pcout_d;
    logic           valid_q, valid_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           push_en;

    // Slots above STACK_DEPTH-1 exist only so SP can index the array at full width;
    // they are never written or read.
    logic [10:0]    stack_q [SLOTS];
    logic [SPW-1:0] sp_m1;

    assign sp_m1        = sp_q - 1'b1;
    assign Rom_addr_out = pc_q;
    assign ir_out       = ir_q;
    assign pc_out       = pcout_q;
    assign ir_valid     = valid_q;
    assign stack_ovf    = ovf_q;
    assign stack_unf    = unf_q;

    // Next-state: fetch latches the ROM word; an accepted issue applies one flow action.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        pcout_d = pcout_q;
        valid_d = valid_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = Rom_data_in;
                pcout_d = pc_q;
                pc_d    = pc_q + 11'd1;
                valid_d = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (valid_q && ir_ready) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                    if (ret_en) begin
                        if (sp_q != '0) begin
                            pc_d = stack_q[sp_m1];
                            sp_d = sp_m1;
                        end else begin
                            unf_d = 1'b1;
                        end
                    end else if (call_en) begin
                        // PC already points past the calling instruction: that is the return address.
                        if (sp_q != SP_FULL) begin
                            push_en = 1'b1;
                            sp_d    = sp_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        pc_d = target_in;
                    end else if (goto_en) begin
                        pc_d = target_in;
                    end else if (skip_en) begin
                        pc_d = pc_q + 11'd1;
                    end
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Control and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_VECTOR;
            ir_q    <= 14'h0;
            pcout_q <= RESET_VECTOR;
            valid_q <= 1'b0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pcout_q <= pcout_d;
            valid_q <= valid_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents are don't-care while SP is zero, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && push_en) begin
            stack_q[sp_q] <= pc_q;
        end
    end

endmodule
